lsu_dmem_master: RTL

- Load/store initiator in the MEM stage. It turns RISC-V load/store requests from the pipeline into word-addressed transactions on the data-memory port.
- Handles byte/half/word sizing, alignment checks, sign/zero extension and pipeline stall.
- Sub-word stores use a read-modify-write sequence when the memory has no byte strobes.
- One outstanding transaction at a time.

---
 rtl/lsu_pkg.sv | 81 ++++++++
 rtl/lsu_lane_align.sv | 27 ++
 rtl/lsu_dmem_master.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and lane helpers.
// Lane helpers assume a 32-bit data word split into four byte lanes.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      StIdle,
      StRdReq,
      StRdWait,
      StRmwReq,
      StRmwWait,
      StWrReq
   } lsu_state_e;

   function automatic logic is_reserved(input logic we, input logic [2:0] funct3);
      if (we) begin
         return funct3[2] || (funct3[1:0] == 2'b11);
      end
      return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
   endfunction

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3[1:0])
         2'b01:   return off[0];
         2'b10:   return |off;
         default: return 1'b0;
      endcase
   endfunction

   // Pull the addressed lane down to bit 0 and extend according to funct3.
   function automatic logic [31:0] lane_extend(input logic [31:0] word,
                                               input logic [2:0]  funct3,
                                               input logic [1:0]  off);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (funct3)
         F3_B:    return {{24{sh[7]}}, sh[7:0]};
         F3_H:    return {{16{sh[15]}}, sh[15:0]};
         F3_BU:   return {24'h000000, sh[7:0]};
         F3_HU:   return {16'h0000, sh[15:0]};
         default: return word;
      endcase
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                              input logic [31:0] data,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  off);
      logic [31:0] mask;
      case (funct3[1:0])
         2'b00:   mask = 32'h0000_00ff;
         2'b01:   mask = 32'h0000_ffff;
         default: mask = 32'hffff_ffff;
      endcase
      mask = mask << {off, 3'b000};
      return (word & ~mask) | ((data << {off, 3'b000}) & mask);
   endfunction

   function automatic logic [31:0] lane_replicate(input logic [31:0] data,
                                                  input logic [2:0]  funct3);
      case (funct3[1:0])
         2'b00:   return {4{data[7:0]}};
         2'b01:   return {2{data[15:0]}};
         default: return data;
      endcase
   endfunction

   function automatic logic [3:0] lane_strobe(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3[1:0])
         2'b00:   return 4'b0001 << off;
         2'b01:   return 4'b0011 << {off[1], 1'b0};
         default: return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extraction/extension and store lane positioning.
// With LSU_BYTE_STROBE_EN the store path replicates data and produces byte enables.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] rword_i,
   input  logic [31:0] sdata_i,
   output logic [31:0] load_o,
   output logic [31:0] store_o
`ifdef LSU_BYTE_STROBE_EN
   ,
   output logic [3:0]  be_o
`endif
);

   assign load_o = lane_extend(rword_i, funct3_i, off_i);

`ifdef LSU_BYTE_STROBE_EN
   assign store_o = lane_replicate(sdata_i, funct3_i);
   assign be_o    = lane_strobe(funct3_i, off_i);
`else
   assign store_o = lane_merge(rword_i, sdata_i, funct3_i, off_i);
`endif

endmodule

// File: rtl/lsu_dmem_master.sv
// MEM-stage load/store initiator driving a word-addressed data-memory port, one access at a time.
// LSU_BYTE_STROBE_EN adds dmem_be and replaces the sub-word read-modify-write with a strobed write.
module lsu_dmem_master
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_AW = 10,
   parameter int unsigned XLEN   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic              lsu_we,
   input  logic [2:0]        lsu_funct3,
   input  logic [XLEN-1:0]   lsu_addr,
   input  logic [XLEN-1:0]   lsu_wdata,
   output logic              lsu_busy,
   output logic              lsu_rvalid,
   output logic [XLEN-1:0]   lsu_rdata,
   output logic              lsu_done,
   output logic              lsu_misalign,
   output logic              lsu_illegal,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [MEM_AW-1:0] dmem_addr,
   output logic [XLEN-1:0]   dmem_wdata,
`ifdef LSU_BYTE_STROBE_EN
   output logic [3:0]        dmem_be,
`endif
   input  logic              dmem_gnt,
   input  logic              dmem_rvalid,
   input  logic [XLEN-1:0]   dmem_rdata
);

   lsu_state_e        state_q, state_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [1:0]        off_q, off_d;
   logic [MEM_AW-1:0] waddr_q, waddr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;
   logic              done_q, done_d;
   logic              misalign_q, misalign_d;
   logic              illegal_q, illegal_d;

   logic              idle;
   logic              accept;
   logic [2:0]        la_funct3;
   logic [1:0]        la_off;
   logic [XLEN-1:0]   la_sdata;
   logic [XLEN-1:0]   la_load;
   logic [XLEN-1:0]   la_store;
   logic              unused_addr;

   assign idle        = (state_q == StIdle);
   assign accept      = lsu_valid && lsu_ready;
   assign unused_addr = ^lsu_addr[XLEN-1:MEM_AW+2];

   // In IDLE the lane logic sees the incoming request; otherwise the captured one.
   assign la_funct3 = idle ? lsu_funct3     : funct3_q;
   assign la_off    = idle ? lsu_addr[1:0]  : off_q;
   assign la_sdata  = idle ? lsu_wdata      : wdata_q;

`ifdef LSU_BYTE_STROBE_EN
   logic [3:0] be_q, be_d;
   logic [3:0] la_be;

   lsu_lane_align u_lane_align (
      .funct3_i (la_funct3),
      .off_i    (la_off),
      .rword_i  (dmem_rdata),
      .sdata_i  (la_sdata),
      .load_o   (la_load),
      .store_o  (la_store),
      .be_o     (la_be)
   );

   assign dmem_be = be_q;
`else
   lsu_lane_align u_lane_align (
      .funct3_i (la_funct3),
      .off_i    (la_off),
      .rword_i  (dmem_rdata),
      .sdata_i  (la_sdata),
      .load_o   (la_load),
      .store_o  (la_store)
   );
`endif

   always_comb begin
      state_d    = state_q;
      funct3_d   = funct3_q;
      off_d      = off_q;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      rvalid_d   = 1'b0;
      done_d     = 1'b0;
      misalign_d = 1'b0;
      illegal_d  = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
`ifdef LSU_BYTE_STROBE_EN
      be_d       = be_q;
`endif

      case (state_q)
         StIdle: begin
            if (accept) begin
               if (is_reserved(lsu_we, lsu_funct3)) begin
                  illegal_d = 1'b1;
               end else if (is_misaligned(lsu_funct3, lsu_addr[1:0])) begin
                  misalign_d = 1'b1;
               end else begin
                  funct3_d = lsu_funct3;
                  off_d    = lsu_addr[1:0];
                  waddr_d  = lsu_addr[MEM_AW+1:2];
                  wdata_d  = lsu_wdata;
`ifdef LSU_BYTE_STROBE_EN
                  be_d     = lsu_we ? la_be : 4'b1111;
                  if (!lsu_we) begin
                     state_d = StRdReq;
                  end else begin
                     wdata_d = la_store;
                     state_d = StWrReq;
                  end
`else
                  if (!lsu_we) begin
                     state_d = StRdReq;
                  end else if (lsu_funct3[1:0] == 2'b10) begin
                     state_d = StWrReq;
                  end else begin
                     state_d = StRmwReq;
                  end
`endif
               end
            end
         end
         StRdReq: begin
            dmem_req = 1'b1;
            if (dmem_gnt) state_d = StRdWait;
         end
         StRdWait: begin
            if (dmem_rvalid) begin
               rdata_d  = la_load;
               rvalid_d = 1'b1;
               state_d  = StIdle;
            end
         end
`ifndef LSU_BYTE_STROBE_EN
         StRmwReq: begin
            dmem_req = 1'b1;
            if (dmem_gnt) state_d = StRmwWait;
         end
         StRmwWait: begin
            if (dmem_rvalid) begin
               wdata_d = la_store;
               state_d = StWrReq;
            end
         end
`endif
         StWrReq: begin
            dmem_req = 1'b1;
            dmem_we  = 1'b1;
            if (dmem_gnt) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         funct3_q   <= 3'b000;
         off_q      <= 2'b00;
         waddr_q    <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
         done_q     <= 1'b0;
         misalign_q <= 1'b0;
         illegal_q  <= 1'b0;
`ifdef LSU_BYTE_STROBE_EN
         be_q       <= 4'b0000;
`endif
      end else begin
         state_q    <= state_d;
         funct3_q   <= funct3_d;
         off_q      <= off_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
         done_q     <= done_d;
         misalign_q <= misalign_d;
         illegal_q  <= illegal_d;
`ifdef LSU_BYTE_STROBE_EN
         be_q       <= be_d;
`endif
      end
   end

   assign lsu_ready    = idle && !rst;
   assign lsu_busy     = !idle;
   assign lsu_rvalid   = rvalid_q;
   assign lsu_rdata    = rdata_q;
   assign lsu_done     = done_q;
   assign lsu_misalign = misalign_q;
   assign lsu_illegal  = illegal_q;
   assign dmem_addr    = waddr_q;
   assign dmem_wdata   = wdata_q;

endmodule
